// File: rtl/icache_direct_pkg.sv
// icache_direct_pkg: shared types and helpers for the direct-mapped instruction cache.
// Revision 1.0
`default_nettype none

package icache_direct_pkg;

  typedef enum logic [2:0] {
    IC_IDLE     = 3'd0,
    IC_LOOKUP   = 3'd1,
    IC_FILL     = 3'd2,
    IC_FILLDONE = 3'd3,
    IC_RESP     = 3'd4
  } icache_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_direct_ram.sv
// icache_ram: single-port synchronous RAM, read-first, one registered read per cycle.
// Revision 1.0
`default_nettype none

module icache_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

`default_nettype wire

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with whole-line sequential fills.
// Revision 1.0
`default_nettype none

module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_enable,
  output logic              cpu_valid,
  output logic [31:0]       cpu_result,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  input  logic              mem_valid,
  input  logic [31:0]       mem_result,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int WB      = $clog2(WORDS_PER_LINE);
  localparam int OFF     = WB + 2;
  localparam int IDX     = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - OFF - IDX;
  localparam int CNT_W   = (WB > 0) ? WB : 1;
  localparam int DADDR_W = IDX + WB;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

  function automatic logic [IDX-1:0] idx_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a >> OFF;
    return s[IDX-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a >> (OFF + IDX);
    return s[TAG_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a >> 2;
    return s[CNT_W-1:0] & LAST;
  endfunction

  // With one word per line the counter bit carries no address information and is shifted out.
  function automatic logic [DADDR_W-1:0] daddr(input logic [IDX-1:0] i, input logic [CNT_W-1:0] w);
    logic [IDX+CNT_W-1:0] cat;
    cat = {i, w};
    cat = cat >> (CNT_W - WB);
    return cat[DADDR_W-1:0];
  endfunction

  icache_state_t     state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              flush_seen_q, flush_seen_d;
  logic [31:0]       fill_word_q, fill_word_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic [31:0]       cpu_result_q, cpu_result_d;
  logic              mem_enable_q, mem_enable_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       hit_q, hit_d;
  logic [31:0]       miss_q, miss_d;

  logic               tag_we, data_we, hit;
  logic [IDX-1:0]     tag_addr, req_idx, cpu_idx;
  logic [TAG_W-1:0]   tag_rdata;
  logic [DADDR_W-1:0] data_addr;
  logic [31:0]        data_rdata;
  logic [ADDR_W-1:0]  line_base;

  icache_ram #(.WIDTH(TAG_W), .DEPTH(LINES), .AW(IDX)) u_tags (
    .clk(clk), .we(tag_we), .addr(tag_addr), .wdata(tag_of(req_addr_q)), .rdata(tag_rdata)
  );

  icache_ram #(.WIDTH(32), .DEPTH(LINES * WORDS_PER_LINE), .AW(DADDR_W)) u_data (
    .clk(clk), .we(data_we), .addr(data_addr), .wdata(mem_result), .rdata(data_rdata)
  );

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    flush_seen_d = flush_seen_q;
    fill_word_d  = fill_word_q;
    cpu_valid_d  = 1'b0;
    cpu_result_d = cpu_result_q;
    mem_enable_d = mem_enable_q;
    mem_addr_d   = mem_addr_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    req_idx      = idx_of(req_addr_q);
    cpu_idx      = idx_of(cpu_addr);
    tag_addr     = req_idx;
    data_addr    = daddr(req_idx, cnt_q);
    line_base    = (req_addr_q >> OFF) << OFF;
    hit          = valid_q[req_idx] && (tag_rdata == tag_of(req_addr_q));

    if (flush) begin
      valid_d = '0;
    end

    case (state_q)
      IC_IDLE: begin
        tag_addr  = cpu_idx;
        data_addr = daddr(cpu_idx, word_of(cpu_addr));
        if (cpu_enable) begin
          req_addr_d = cpu_addr;
          state_d    = IC_LOOKUP;
        end
      end
      IC_LOOKUP: begin
        if (hit) begin
          cpu_result_d = data_rdata;
          cpu_valid_d  = 1'b1;
          hit_d        = sat_inc32(hit_q);
          state_d      = IC_RESP;
        end else begin
          miss_d       = sat_inc32(miss_q);
          cnt_d        = '0;
          flush_seen_d = 1'b0;
          mem_enable_d = 1'b1;
          mem_addr_d   = line_base;
          state_d      = IC_FILL;
        end
      end
      IC_FILL: begin
        if (flush) begin
          flush_seen_d = 1'b1;
        end
        if (mem_valid && mem_enable_q) begin
          data_we      = 1'b1;
          mem_enable_d = 1'b0;
          if (cnt_q == word_of(req_addr_q)) begin
            fill_word_d = mem_result;
          end
          if (cnt_q == LAST) begin
            tag_we = 1'b1;
            if (!(flush_seen_q || flush)) begin
              valid_d[req_idx] = 1'b1;
            end
            state_d = IC_FILLDONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!mem_enable_q) begin
          // Gap cycle after each word: re-request the next word of the line.
          mem_enable_d = 1'b1;
          mem_addr_d   = line_base | (ADDR_W'(cnt_q) << 2);
        end
      end
      IC_FILLDONE: begin
        cpu_result_d = fill_word_q;
        cpu_valid_d  = 1'b1;
        state_d      = IC_RESP;
      end
      IC_RESP: begin
        state_d = IC_IDLE;
      end
      default: begin
        state_d = IC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IC_IDLE;
      req_addr_q   <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      flush_seen_q <= 1'b0;
      fill_word_q  <= '0;
      cpu_valid_q  <= 1'b0;
      cpu_result_q <= '0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      flush_seen_q <= flush_seen_d;
      fill_word_q  <= fill_word_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_result_q <= cpu_result_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign cpu_valid  = cpu_valid_q;
  assign cpu_result = cpu_result_q;
  assign mem_enable = mem_enable_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed self-checking bench for icache_direct with a fixed-latency controller model.
// Revision 1.0
`default_nettype none

module tb_icache_direct;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic        cpu_enable = 1'b0;
  logic        cpu_valid;
  logic [31:0] cpu_result;
  logic        flush = 1'b0;
  logic [24:0] mem_addr;
  logic        mem_enable;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_result = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int failures = 0;

  logic [24:0] addr_log[$];
  int          mem_en_cycles = 0;
  int          stab_err = 0;
  int          lat_cnt = 0;
  logic        prev_en = 1'b0;
  logic [24:0] prev_addr = '0;

  icache_direct #(.LINES(64), .WORDS_PER_LINE(4), .ADDR_W(25)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_enable(cpu_enable),
    .cpu_valid(cpu_valid), .cpu_result(cpu_result), .flush(flush),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_valid(mem_valid),
    .mem_result(mem_result), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [24:0] a);
    case (a)
      25'h40:  return 32'h11;
      25'h44:  return 32'h22;
      25'h48:  return 32'h33;
      25'h4C:  return 32'h44;
      default: return 32'hD000_0000 | {7'd0, a};
    endcase
  endfunction

  // Controller model: mem_valid pulses MEM_LAT cycles after mem_enable rises.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_valid = 1'b0;
      lat_cnt   = 0;
      prev_en   = 1'b0;
    end else begin
      if (mem_enable) mem_en_cycles++;
      if (mem_enable && prev_en && mem_addr !== prev_addr) stab_err++;
      prev_en   = mem_enable;
      prev_addr = mem_addr;
      if (mem_valid) begin
        mem_valid = 1'b0;
      end else if (mem_enable) begin
        lat_cnt++;
        if (lat_cnt == MEM_LAT) begin
          mem_valid  = 1'b1;
          mem_result = mem_word(mem_addr);
          addr_log.push_back(mem_addr);
          lat_cnt    = 0;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic do_fetch(input logic [24:0] a, input bit use_flush, input logic [24:0] flush_at,
                          output logic [31:0] res, output int lat, output bit ok);
    bit flushed;
    flushed = 1'b0;
    ok = 1'b0;
    lat = 0;
    res = '0;
    @(negedge clk);
    cpu_addr = a;
    cpu_enable = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      lat++;
      flush = 1'b0;
      if (use_flush && !flushed && mem_enable && mem_addr == flush_at) begin
        flush = 1'b1;
        flushed = 1'b1;
      end
      if (cpu_valid) begin
        ok = 1'b1;
        res = cpu_result;
        cpu_enable = 1'b0;
      end
    end
    flush = 1'b0;
    cpu_enable = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cpu_valid !== 1'b0) begin failures++; $display("FAIL reset_cpu_valid got=%0h exp=0", cpu_valid); end
    checks++; if (cpu_result !== 32'h0) begin failures++; $display("FAIL reset_cpu_result got=%0h exp=0", cpu_result); end
    checks++; if (mem_enable !== 1'b0) begin failures++; $display("FAIL reset_mem_enable got=%0h exp=0", mem_enable); end
    checks++; if (mem_addr !== 25'h0) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (hit_count !== 32'h0) begin failures++; $display("FAIL reset_hit_count got=%0h exp=0", hit_count); end
    checks++; if (miss_count !== 32'h0) begin failures++; $display("FAIL reset_miss_count got=%0h exp=0", miss_count); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] res; int lat; bit ok;
    logic [24:0] exp_addr [4];
    exp_addr[0] = 25'h40; exp_addr[1] = 25'h44; exp_addr[2] = 25'h48; exp_addr[3] = 25'h4C;
    addr_log.delete();
    do_fetch(25'h40, 1'b0, '0, res, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cold_timeout got=no_valid exp=valid"); end
    checks++; if (res !== 32'h11) begin failures++; $display("FAIL cold_result got=%0h exp=11", res); end
    checks++; if (lat !== 18) begin failures++; $display("FAIL cold_latency got=%0d exp=18", lat); end
    checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL cold_miss_count got=%0d exp=1", miss_count); end
    checks++; if (addr_log.size() !== 4) begin failures++; $display("FAIL cold_addr_count got=%0d exp=4", addr_log.size()); end
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      checks++;
      if (addr_log[i] !== exp_addr[i]) begin failures++; $display("FAIL cold_mem_addr[%0d] got=%0h exp=%0h", i, addr_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_hit();
    logic [31:0] res; int lat; bit ok; int en0;
    en0 = mem_en_cycles;
    do_fetch(25'h48, 1'b0, '0, res, lat, ok);
    checks++; if (!ok || lat !== 2) begin failures++; $display("FAIL hit_latency got=%0d exp=2", lat); end
    checks++; if (res !== 32'h33) begin failures++; $display("FAIL hit_result got=%0h exp=33", res); end
    checks++; if (hit_count !== 32'd1) begin failures++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
    checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL hit_miss_count got=%0d exp=1", miss_count); end
    checks++; if (mem_en_cycles !== en0) begin failures++; $display("FAIL hit_mem_traffic got=%0d exp=%0d", mem_en_cycles, en0); end
    @(negedge clk);
    checks++; if (cpu_valid !== 1'b0) begin failures++; $display("FAIL hit_valid_pulse got=%0h exp=0", cpu_valid); end
  endtask

  task automatic test_conflict();
    logic [31:0] res; int lat; bit ok;
    logic [24:0] a [3];
    logic [31:0] e [3];
    a[0] = 25'h1040; a[1] = 25'h40; a[2] = 25'h1040;
    e[0] = 32'hD000_1040; e[1] = 32'h11; e[2] = 32'hD000_1040;
    for (int k = 0; k < 3; k++) begin
      addr_log.delete();
      do_fetch(a[k], 1'b0, '0, res, lat, ok);
      checks++; if (res !== e[k]) begin failures++; $display("FAIL conflict_result[%0d] got=%0h exp=%0h", k, res, e[k]); end
      checks++; if (miss_count !== 32'(2 + k)) begin failures++; $display("FAIL conflict_miss[%0d] got=%0d exp=%0d", k, miss_count, 2 + k); end
      checks++; if (addr_log.size() !== 4) begin failures++; $display("FAIL conflict_refill[%0d] got=%0d exp=4", k, addr_log.size()); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; bit ok;
    do_fetch(25'h1048, 1'b0, '0, res, lat, ok);
    checks++; if (res !== 32'hD000_1048 || hit_count !== 32'd2) begin failures++; $display("FAIL preflush_hit got=%0h/%0d exp=d0001048/2", res, hit_count); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    do_fetch(25'h1048, 1'b0, '0, res, lat, ok);
    checks++; if (res !== 32'hD000_1048) begin failures++; $display("FAIL flush_result got=%0h exp=d0001048", res); end
    checks++; if (miss_count !== 32'd5 || hit_count !== 32'd2) begin failures++; $display("FAIL flush_miss got=%0d/%0d exp=5/2", miss_count, hit_count); end
    do_fetch(25'h1048, 1'b0, '0, res, lat, ok);
    checks++; if (lat !== 2 || hit_count !== 32'd3) begin failures++; $display("FAIL flush_rehit got=%0d/%0d exp=2/3", lat, hit_count); end
  endtask

  task automatic test_flush_during_fill();
    logic [31:0] res; int lat; bit ok;
    do_fetch(25'h80, 1'b1, 25'h84, res, lat, ok);
    checks++; if (!ok || res !== 32'hD000_0080) begin failures++; $display("FAIL fillflush_result got=%0h exp=d0000080", res); end
    checks++; if (miss_count !== 32'd6) begin failures++; $display("FAIL fillflush_miss got=%0d exp=6", miss_count); end
    do_fetch(25'h80, 1'b0, '0, res, lat, ok);
    checks++; if (miss_count !== 32'd7 || hit_count !== 32'd3) begin failures++; $display("FAIL fillflush_refetch got=%0d/%0d exp=7/3", miss_count, hit_count); end
    do_fetch(25'h84, 1'b0, '0, res, lat, ok);
    checks++; if (res !== 32'hD000_0084 || hit_count !== 32'd4) begin failures++; $display("FAIL fillflush_hit got=%0h/%0d exp=d0000084/4", res, hit_count); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL mem_addr_stable got=%0d exp=0", stab_err); end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] res; int lat; bit ok; bit seen;
    seen = 1'b0;
    @(negedge clk);
    cpu_addr = 25'h100;
    cpu_enable = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mem_enable && mem_addr == 25'h108) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rstfill_reach got=no_word2 exp=word2"); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_enable !== 1'b0) begin failures++; $display("FAIL rstfill_mem_enable got=%0h exp=0", mem_enable); end
    checks++; if (mem_addr !== 25'h0 || cpu_valid !== 1'b0 || cpu_result !== 32'h0) begin failures++; $display("FAIL rstfill_outputs got=%0h/%0h/%0h exp=0/0/0", mem_addr, cpu_valid, cpu_result); end
    checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin failures++; $display("FAIL rstfill_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
    cpu_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_fetch(25'h100, 1'b0, '0, res, lat, ok);
    checks++; if (res !== 32'hD000_0100 || miss_count !== 32'd1) begin failures++; $display("FAIL rstfill_refetch got=%0h/%0d exp=d0000100/1", res, miss_count); end
    do_fetch(25'h84, 1'b0, '0, res, lat, ok);
    checks++; if (miss_count !== 32'd2 || hit_count !== 32'd0) begin failures++; $display("FAIL rstfill_invalid got=%0d/%0d exp=2/0", miss_count, hit_count); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_flush_during_fill();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the SDRAM controller's instruction port.
- CPU side uses the same enable/valid handshake the controller presents. The memory side drives the controller's instr_addr/instr_enable and consumes instr_valid/instr_result.
- Misses fill a whole line with sequential word reads. Hits return in 2 cycles with no SDRAM traffic.

Parameters:
- LINES, 64, number of cache lines; power of 2, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, ≥1.
- ADDR_W, 25, byte-address width on both sides.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored.
- cpu_enable  in  1  fetch request; held high with stable cpu_addr until cpu_valid.
- cpu_valid  out  1  one-cycle pulse; cpu_result valid this cycle.
- cpu_result  out  32  fetched instruction word.
- flush  in  1  single-cycle pulse; invalidates all lines.
- mem_addr  out  ADDR_W  word-aligned byte address to the SDRAM controller.
- mem_enable  out  1  read request to the controller.
- mem_valid  in  1  controller word-ready pulse.
- mem_result  in  32  controller read data.
- hit_count  out  32  saturating count of hits.
- miss_count  out  32  saturating count of misses.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)+2, IDX = log2(LINES).
  - word = addr[OFF-1:2], index = addr[OFF+IDX-1:OFF], tag = addr[ADDR_W-1:OFF+IDX].
- Storage:
  - valid bit per line in flops.
  - Tag array and data array (LINES*WORDS_PER_LINE words) are synchronous-read RAM.
- Reset values:
  - All valid bits 0.
  - cpu_valid 0, cpu_result 0, mem_enable 0, mem_addr 0, counters 0.
  - State IDLE.
- State machine:
  - IDLE: when cpu_enable=1, latch cpu_addr into req_addr and issue the tag/data RAM read. Go to LOOKUP.
  - LOOKUP: compare stored tag and valid bit.
    - Hit: register the data word into cpu_result, pulse cpu_valid, increment hit_count. Go to RESP.
    - Miss: increment miss_count, set fill counter to 0. Go to FILL.
  - FILL:
    - mem_addr = {req_addr line base, counter, 2'b00}; mem_enable=1.
    - On mem_valid: write mem_result to the data RAM at (index, counter), drop mem_enable for exactly one cycle, increment counter.
    - After word WORDS_PER_LINE-1: write tag, set valid[index] (unless a flush occurred during the fill). Go to FILLDONE.
  - FILLDONE: read the requested word. Go to LOOKUP-equivalent response: cpu_result = requested word, cpu_valid pulse. Go to RESP.
    - The miss is not re-counted as a hit.
  - RESP: one dead cycle with cpu_enable ignored, so the CPU's registered enable drop is absorbed. Return to IDLE.
- Latency:
  - Hit: cpu_valid asserted 2 cycles after the first cycle cpu_enable is sampled high.
  - Miss: 2 + the sum of per-word controller latencies + WORDS_PER_LINE-1 gap cycles + 1.
- Fill order is always word 0 to last. The requested word is returned only after the full line is filled.
- cpu_valid is high for exactly one cycle per request. It is never asserted outside LOOKUP/FILLDONE exits.
- mem_addr is stable whenever mem_enable=1. mem_enable is never high in IDLE, LOOKUP or RESP.
- flush:
  - In IDLE/LOOKUP/RESP: all valid bits cleared on the next edge.
    - A flush coincident with a LOOKUP hit: the hit is still served (data is coherent for the current fetch); lines are invalid afterwards.
  - During FILL: the in-progress fill completes and the word is returned, but valid[index] stays 0.
- Counters saturate at 32'hFFFF_FFFF.
- cpu_addr change while cpu_enable is high before cpu_valid: protocol violation. The block uses the latched req_addr.
- Asynchronous reset mid-fill: immediate return to reset values. mem_enable drops combinationally with reset assertion via the flop. Partial line stays invalid.

Decomposition:
- defs package gains icache_state_t (IC_IDLE, IC_LOOKUP, IC_FILL, IC_FILLDONE, IC_RESP).
- Address-split widths are derived locally from parameters via localparams; no package constants needed.
- One sub-module: icache_ram, a parameterised single-port synchronous RAM (width, depth, write enable). It is instantiated twice: tags and data.

Test Plan:
- Cold miss, address 0x000040, controller returns 0x11, 0x22, 0x33, 0x44 with 3-cycle latency each:
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - cpu_result = 0x11.
  - miss_count = 1.
- Fetch 0x000048 immediately after: hit; cpu_valid 2 cycles after enable, cpu_result = 0x33, no mem_enable, hit_count = 1.
- Conflict with LINES=64, WPL=4: fetch 0x000040, then 0x001040 (same index, tag differs), then 0x000040 again → three misses, line refilled each time.
- flush pulse, then fetch 0x000048 → miss and refill; miss_count increments.
- flush asserted during the 2nd word of a fill for 0x000080:
  - Requested word is still returned.
  - Re-fetching 0x000080 misses again.
- rst_n low during the 3rd fill word:
  - Outputs return to reset values; mem_enable = 0.
  - After release, a fetch of the same address misses.
